mult_share_ctrl: RTL and testbench

//  Shares one pipelined mult32 datapath among NUM_REQ requesters, e.g. tick_logic and a second operand source.

---
 rtl/mult_share_ctrl.sv | 156 +++++++++++++++
 tb/tb_mult_share_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_ctrl.sv
// Round-robin front end that time-shares one external pipelined multiplier
// among NUM_REQ requesters, returning each product into a per-requester hold register.

module mult_share_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             capture,
  input  logic [WIDTH-1:0] mul_p,
  input  logic             rsp_ready,
  output logic             busy,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data
);
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Busy spans accept through response handshake, so capture and handshake never collide.
  always_comb begin
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      busy_d      = 1'b0;
    end
    if (capture) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = mul_p;
    end
    if (accept) busy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
endmodule

module mult_share_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [NUM_REQ*WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [WIDTH-1:0]         mul_p,
  output logic                     idle
);
  localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = LATENCY - 1;

  logic [NUM_REQ-1:0][WIDTH-1:0] a_v, b_v, rsp_data_v;
  logic [NUM_REQ-1:0]            busy, elig, cap;
  logic [PW-1:0]                 rr_ptr_q, rr_ptr_d, grant_idx;
  logic [PW:0]                   idx_sum;
  logic                          any_grant;
  logic [WIDTH-1:0]              mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [STAGES:0]               vld_pipe_q, vld_pipe_d;
  logic [STAGES:0][PW-1:0]       id_pipe_q, id_pipe_d;

  assign a_v  = req_a;
  assign b_v  = req_b;
  assign elig = req_valid & ~busy;

  // Scan rr_ptr, rr_ptr+1, ... with explicit wrap so non-power-of-two NUM_REQ works.
  always_comb begin
    any_grant = 1'b0;
    grant_idx = '0;
    idx_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (idx_sum >= (PW+1)'(NUM_REQ)) idx_sum = idx_sum - (PW+1)'(NUM_REQ);
      if (!any_grant && elig[idx_sum[PW-1:0]]) begin
        any_grant = 1'b1;
        grant_idx = idx_sum[PW-1:0];
      end
    end
  end

  assign req_ready = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rr_ptr_d   = rr_ptr_q;
    vld_pipe_d = {vld_pipe_q[STAGES-1+1-1:0], any_grant};
    id_pipe_d  = id_pipe_q;
    for (int s = STAGES; s > 0; s--) id_pipe_d[s] = id_pipe_q[s-1];
    id_pipe_d[0] = grant_idx;
    if (any_grant) begin
      mul_a_d  = a_v[grant_idx];
      mul_b_d  = b_v[grant_idx];
      rr_ptr_d = (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      rr_ptr_q   <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      rr_ptr_q   <= rr_ptr_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign cap[i] = vld_pipe_q[STAGES] && (id_pipe_q[STAGES] == PW'(i));
    mult_share_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .accept    (req_ready[i]),
      .capture   (cap[i]),
      .mul_p     (mul_p),
      .rsp_ready (rsp_ready[i]),
      .busy      (busy[i]),
      .rsp_valid (rsp_valid[i]),
      .rsp_data  (rsp_data_v[i])
    );
  end

  assign rsp_data = rsp_data_v;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign idle     = ~|busy;
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed ops into a per-requester expected-product
// scoreboard, popped by a monitor on every response handshake.

module tb_mult_share_ctrl;
  localparam int NR = 2;
  localparam int W  = 32;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*W-1:0] req_a, req_b, rsp_data;
  logic [W-1:0]  mul_a, mul_b, mul_p;
  logic          idle;

  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q [NR][$];
  logic [W-1:0] mpipe [1:L-1];

  always #5 clk = ~clk;

  mult_share_ctrl #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .idle(idle)
  );

  // External multiplier: L-1 register stages so mul_p is sampled L edges after mul_a/mul_b.
  always @(posedge clk) begin
    mpipe[1] <= mul_a * mul_b;
    for (int s = 2; s < L; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_p = mpipe[L-1];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: every handshake the DUT is about to see is compared with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("req_ready_onehot", W'($countones(req_ready) <= 1), 1);
        for (int i = 0; i < NR; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            if (exp_q[i].size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL rsp_unexpected: requester %0d data %h with empty scoreboard", i, rsp_data[i*W +: W]);
            end else begin
              chk($sformatf("rsp_data%0d", i), rsp_data[i*W +: W], exp_q[i].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] opa [NR][3] = '{'{32'd7, 32'd100, 32'hFFFF_FFFF}, '{32'd9, 32'd1000, 32'h0001_0000}};
  logic [W-1:0] opb [NR][3] = '{'{32'd6, 32'd200, 32'd2},         '{32'd9, 32'd1000, 32'h0001_0000}};
  logic [W-1:0] opp [NR][3] = '{'{32'd42, 32'd20000, 32'hFFFF_FFFE}, '{32'd81, 32'd1000000, 32'h0}};

  initial begin
    int cnt [NR];
    int expg, g, cyc;
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_idle", idle, 1);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_rsp_data0", rsp_data[0 +: W], 0);
    chk("rst_rsp_data1", rsp_data[W +: W], 0);
    rst_n = 1'b1;
    tick();

    // Single op 3*5, result held while rsp_ready is low, busy blocks re-grant.
    req_a[0 +: W] = 32'd3; req_b[0 +: W] = 32'd5; req_valid = 2'b01; #1;
    chk("single_grant", req_ready, 2'b01);
    tick(); exp_q[0].push_back(32'd15);
    chk("single_mul_a", mul_a, 3);
    chk("single_mul_b", mul_b, 5);
    chk("busy_block", req_ready, 0);
    chk("busy_idle", idle, 0);
    repeat (3) tick();
    chk("pre_latency_rsp", rsp_valid, 0);
    tick();
    chk("latency_rsp_valid", rsp_valid, 2'b01);
    chk("latency_rsp_data", rsp_data[0 +: W], 15);
    repeat (2) tick();
    chk("hold_rsp_valid", rsp_valid, 2'b01);
    chk("hold_rsp_data", rsp_data[0 +: W], 15);
    chk("hold_busy_block", req_ready, 0);
    rsp_ready = 2'b01;
    tick();
    chk("hs_rsp_valid", rsp_valid, 0);
    chk("hs_regrant", req_ready, 2'b01);
    chk("hs_data_hold", rsp_data[0 +: W], 15);

    // Wrap-around: low WIDTH bits of FFFFFFFF*2.
    req_a[0 +: W] = 32'hFFFF_FFFF; req_b[0 +: W] = 32'd2;
    tick(); exp_q[0].push_back(32'hFFFF_FFFE);
    req_valid = '0;
    repeat (7) tick();
    chk("wrap_idle", idle, 1);
    chk("mul_a_no_toggle", mul_a, 32'hFFFF_FFFF);

    // Round-robin: rr_ptr is 1 after the last grant to requester 0.
    rsp_ready = 2'b11; cnt[0] = 0; cnt[1] = 0; expg = 1;
    for (cyc = 0; cyc < 80 && (cnt[0] < 3 || cnt[1] < 3); cyc++) begin
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = (cnt[i] < 3);
        if (cnt[i] < 3) begin
          req_a[i*W +: W] = opa[i][cnt[i]];
          req_b[i*W +: W] = opb[i][cnt[i]];
        end
      end
      #1;
      if (req_ready != 0) begin
        g = req_ready[1] ? 1 : 0;
        chk("rr_grant", g, expg);
        expg = 1 - expg;
        exp_q[g].push_back(opp[g][cnt[g]]);
        cnt[g]++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("rr_grant_count", cnt[0] + cnt[1], 6);
    repeat (8) tick();
    chk("rr_idle", idle, 1);
    chk("rr_q0_empty", exp_q[0].size(), 0);
    chk("rr_q1_empty", exp_q[1].size(), 0);

    // Simultaneous capture of req0 and accept of req1 on the same edge.
    rsp_ready = 2'b00;
    req_a[0 +: W] = 32'd11; req_b[0 +: W] = 32'd13; req_valid = 2'b01; #1;
    chk("sim_grant0", req_ready, 2'b01);
    tick(); exp_q[0].push_back(32'd143);
    req_valid = '0;
    repeat (3) tick();
    req_a[W +: W] = 32'd20; req_b[W +: W] = 32'd30; req_valid = 2'b10; #1;
    chk("sim_grant1", req_ready, 2'b10);
    tick(); exp_q[1].push_back(32'd600);
    chk("sim_capture0", rsp_valid, 2'b01);
    chk("sim_busy1", req_ready, 0);
    chk("sim_idle", idle, 0);
    req_valid = '0; rsp_ready = 2'b11;
    repeat (7) tick();
    chk("sim_done_idle", idle, 1);
    chk("sim_done_rsp", rsp_valid, 0);

    // Reset with two ops in flight: products must be dropped.
    rsp_ready = 2'b00;
    req_a[0 +: W] = 32'd2; req_b[0 +: W] = 32'd2;
    req_a[W +: W] = 32'd3; req_b[W +: W] = 32'd3;
    req_valid = 2'b11;
    tick(); tick();
    req_valid = '0;
    tick();
    chk("mid_idle_before_rst", idle, 0);
    rst_n = 1'b0; #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_idle", idle, 1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    chk("post_rst_idle", idle, 1);

    // Post-reset op from requester 1 (rr_ptr back at 0).
    rsp_ready = 2'b10;
    req_a[W +: W] = 32'h1234; req_b[W +: W] = 32'h10; req_valid = 2'b10; #1;
    chk("post_rst_grant1", req_ready, 2'b10);
    tick(); exp_q[1].push_back(32'h0001_2340);
    req_valid = '0;
    repeat (8) tick();
    chk("final_idle", idle, 1);
    chk("final_q0_empty", exp_q[0].size(), 0);
    chk("final_q1_empty", exp_q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
